fp_exp_pipe: RTL and testbench

Pipelined, parametrised exponent datapath for the floating-point multiplier. It adds two biased operand exponents with a grouped carry-lookahead adder, then applies the normalisation increment and removes the bias. It classifies the result as normal, overflow, underflow, zero or NaN, and saturates the exponent accordingly. It sits between operand unpacking and final result packing, and uses a valid/ready handshake with full throughput and 2-cycle latency.

---
 rtl/fp_exp_pipe.sv | 184 ++++++++++++++++++
 tb/tb_fp_exp_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_exp_pipe.sv
// FP multiplier exponent path: lookahead add of biased exponents, normalise, unbias, classify, saturate.
// Two register stages at full throughput; in_ready falls only when both stages are full and out_ready is low.
module fp_exp_pipe #(
    parameter int EXP_WIDTH     = 8,
    parameter int BIAS          = 127,
    parameter int CLA_GRP_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_WIDTH-1:0] exp_a,
    input  logic [EXP_WIDTH-1:0] exp_b,
    input  logic                 norm_inc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_WIDTH-1:0] exp_out,
    output logic                 ovf,
    output logic                 unf,
    output logic                 is_zero,
    output logic                 is_nan,
    output logic                 is_inf
);
    localparam int NGRP = EXP_WIDTH / CLA_GRP_WIDTH;
    localparam logic signed [EXP_WIDTH+1:0] C_BIAS = (EXP_WIDTH+2)'(BIAS);
    localparam logic signed [EXP_WIDTH+1:0] C_EMAX = {2'b00, {EXP_WIDTH{1'b1}}};

    logic                 r_s1_valid;
    logic [EXP_WIDTH-1:0] r_s1_a;
    logic [EXP_WIDTH-1:0] r_s1_b;
    logic                 r_s1_inc;
    logic                 r_s1_za;
    logic                 r_s1_zb;
    logic                 r_s1_ia;
    logic                 r_s1_ib;

    logic                 r_s2_valid;
    logic [EXP_WIDTH-1:0] r_exp;
    logic                 r_ovf;
    logic                 r_unf;
    logic                 r_zero;
    logic                 r_nan;
    logic                 r_inf;

    logic                 w_adv1;
    logic                 w_adv2;

    logic [EXP_WIDTH-1:0] w_g;
    logic [EXP_WIDTH-1:0] w_p;
    logic [NGRP-1:0]      w_grp_g;
    logic [NGRP-1:0]      w_grp_p;
    logic [NGRP:0]        w_gc;
    logic                 w_term;
    logic                 w_c;
    logic [EXP_WIDTH-1:0] w_sum;
    logic [EXP_WIDTH:0]   w_raw;

    logic signed [EXP_WIDTH+1:0] w_r;
    logic [EXP_WIDTH-1:0] w_nxt_exp;
    logic                 w_nxt_ovf;
    logic                 w_nxt_unf;
    logic                 w_nxt_zero;
    logic                 w_nxt_nan;
    logic                 w_nxt_inf;

    // No skid buffer: a draining output frees both stages in the same cycle.
    assign w_adv2   = !r_s2_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_inc   <= 1'b0;
            r_s1_za    <= 1'b0;
            r_s1_zb    <= 1'b0;
            r_s1_ia    <= 1'b0;
            r_s1_ib    <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid && w_adv1;
            if (in_valid) begin
                r_s1_a   <= exp_a;
                r_s1_b   <= exp_b;
                r_s1_inc <= norm_inc;
                r_s1_za  <= (exp_a == '0);
                r_s1_zb  <= (exp_b == '0);
                r_s1_ia  <= (exp_a == '1);
                r_s1_ib  <= (exp_b == '1);
            end
        end
    end

    // Group carries are flat sum-of-products over lower groups so no carry ripples between groups.
    always_comb begin
        w_g     = r_s1_a & r_s1_b;
        w_p     = r_s1_a ^ r_s1_b;
        w_grp_g = '0;
        w_grp_p = '1;
        w_gc    = '0;
        w_term  = 1'b0;
        w_c     = 1'b0;
        w_sum   = '0;
        for (int j = 0; j < NGRP; j++) begin
            for (int k = 0; k < CLA_GRP_WIDTH; k++) begin
                w_grp_g[j] = w_g[j*CLA_GRP_WIDTH+k] | (w_p[j*CLA_GRP_WIDTH+k] & w_grp_g[j]);
                w_grp_p[j] = w_grp_p[j] & w_p[j*CLA_GRP_WIDTH+k];
            end
        end
        for (int j = 1; j <= NGRP; j++) begin
            for (int k = 0; k < j; k++) begin
                w_term = w_grp_g[k];
                for (int m = k + 1; m < j; m++) begin
                    w_term = w_term & w_grp_p[m];
                end
                w_gc[j] = w_gc[j] | w_term;
            end
        end
        for (int j = 0; j < NGRP; j++) begin
            w_c = w_gc[j];
            for (int k = 0; k < CLA_GRP_WIDTH; k++) begin
                w_sum[j*CLA_GRP_WIDTH+k] = w_p[j*CLA_GRP_WIDTH+k] ^ w_c;
                w_c = w_g[j*CLA_GRP_WIDTH+k] | (w_p[j*CLA_GRP_WIDTH+k] & w_c);
            end
        end
        w_raw = {w_gc[NGRP], w_sum};
    end

    always_comb begin
        w_r = $signed({1'b0, w_raw}) + $signed({{(EXP_WIDTH+1){1'b0}}, r_s1_inc}) - C_BIAS;
        w_nxt_exp  = w_r[EXP_WIDTH-1:0];
        w_nxt_ovf  = 1'b0;
        w_nxt_unf  = 1'b0;
        w_nxt_zero = 1'b0;
        w_nxt_nan  = 1'b0;
        w_nxt_inf  = 1'b0;
        if ((r_s1_za || r_s1_zb) && (r_s1_ia || r_s1_ib)) begin
            w_nxt_exp = '1;
            w_nxt_nan = 1'b1;
        end else if (r_s1_za || r_s1_zb) begin
            w_nxt_exp  = '0;
            w_nxt_zero = 1'b1;
        end else if (r_s1_ia || r_s1_ib) begin
            w_nxt_exp = '1;
            w_nxt_inf = 1'b1;
        end else if (w_r >= C_EMAX) begin
            w_nxt_exp = '1;
            w_nxt_ovf = 1'b1;
        end else if (w_r[EXP_WIDTH+1] || (w_r == '0)) begin
            w_nxt_exp = '0;
            w_nxt_unf = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_exp      <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_zero     <= 1'b0;
            r_nan      <= 1'b0;
            r_inf      <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            r_exp      <= w_nxt_exp;
            r_ovf      <= w_nxt_ovf;
            r_unf      <= w_nxt_unf;
            r_zero     <= w_nxt_zero;
            r_nan      <= w_nxt_nan;
            r_inf      <= w_nxt_inf;
        end
    end

    assign out_valid = r_s2_valid;
    assign exp_out   = r_exp;
    assign ovf       = r_ovf;
    assign unf       = r_unf;
    assign is_zero   = r_zero;
    assign is_nan    = r_nan;
    assign is_inf    = r_inf;

endmodule

// File: tb/tb_fp_exp_pipe.sv
// Bench for fp_exp_pipe: directed vectors with fixed expectations, plus random streams
// scored against an integer-arithmetic reference model with random backpressure.
module tb_fp_exp_pipe;
    localparam int EW   = 8;
    localparam int BIAS = 127;
    localparam int EMAX = (1 << EW) - 1;

    typedef struct packed {
        logic [EW-1:0] e;
        logic [4:0]    fl;   // {ovf, unf, is_zero, is_nan, is_inf}
    } res_t;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [EW-1:0] exp_a     = '0;
    logic [EW-1:0] exp_b     = '0;
    logic          norm_inc  = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [EW-1:0] exp_out;
    logic          ovf, unf, is_zero, is_nan, is_inf;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fp_exp_pipe #(.EXP_WIDTH(EW), .BIAS(BIAS), .CLA_GRP_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .exp_a(exp_a), .exp_b(exp_b), .norm_inc(norm_inc),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_out(exp_out), .ovf(ovf), .unf(unf),
        .is_zero(is_zero), .is_nan(is_nan), .is_inf(is_inf)
    );

    function automatic res_t model(input int a, input int b, input int inc);
        res_t m;
        int   r;
        bit   z, i;
        z = (a == 0) || (b == 0);
        i = (a == EMAX) || (b == EMAX);
        r = a + b + inc - BIAS;
        m.e  = EW'(r);
        m.fl = 5'b00000;
        if (z && i)         begin m.e = EW'(EMAX); m.fl = 5'b00010; end
        else if (z)         begin m.e = '0;        m.fl = 5'b00100; end
        else if (i)         begin m.e = EW'(EMAX); m.fl = 5'b00001; end
        else if (r >= EMAX) begin m.e = EW'(EMAX); m.fl = 5'b10000; end
        else if (r <= 0)    begin m.e = '0;        m.fl = 5'b01000; end
        return m;
    endfunction

    function automatic res_t observed();
        res_t o;
        o.e  = exp_out;
        o.fl = {ovf, unf, is_zero, is_nan, is_inf};
        return o;
    endfunction

    function automatic int pick_exp();
        int s;
        s = int'($urandom_range(0, 9));
        if (s == 0) return 0;
        if (s == 1) return EMAX;
        return int'($urandom_range(0, EMAX));
    endfunction

    // Presents one operand set on an empty pipe, then samples out_valid one and two cycles later.
    task automatic send_single(input int a, input int b, input int inc,
                               output logic v1, output logic v2, output res_t got);
        @(negedge clk);
        exp_a = EW'(a); exp_b = EW'(b); norm_inc = inc[0];
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        v1 = out_valid;
        @(negedge clk);
        v2 = out_valid;
        got = observed();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || exp_out !== '0 || {ovf, unf, is_zero, is_nan, is_inf} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b exp=%0d flags=%b, want 0/0/00000",
                     out_valid, exp_out, {ovf, unf, is_zero, is_nan, is_inf});
        end
        #2 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_normal();
        int   va[4] = '{130, 130, 63, 190};
        int   vb[4] = '{125, 125, 64, 191};
        int   vi[4] = '{0, 1, 1, 0};
        int   ve[4] = '{128, 129, 1, 254};
        logic v1, v2;
        res_t got;
        for (int k = 0; k < 4; k++) begin
            send_single(va[k], vb[k], vi[k], v1, v2, got);
            n_cmp++;
            if (v1 !== 1'b0 || v2 !== 1'b1) begin
                n_fail++;
                $display("FAIL normal_latency[%0d]: out_valid at +1/+2 = %b/%b, want 0/1", k, v1, v2);
            end
            n_cmp++;
            if (got.e !== EW'(ve[k]) || got.fl !== 5'b0) begin
                n_fail++;
                $display("FAIL normal_value[%0d]: exp=%0d flags=%b, want exp=%0d flags=00000",
                         k, got.e, got.fl, ve[k]);
            end
        end
    endtask

    task automatic test_saturation();
        int   va[6] = '{200, 190, 254, 60, 63, 1};
        int   vb[6] = '{200, 191, 200, 60, 64, 1};
        int   vi[6] = '{0, 1, 1, 0, 0, 0};
        int   ve[6] = '{255, 255, 255, 0, 0, 0};
        int   vf[6] = '{5'b10000, 5'b10000, 5'b10000, 5'b01000, 5'b01000, 5'b01000};
        logic v1, v2;
        res_t got;
        for (int k = 0; k < 6; k++) begin
            send_single(va[k], vb[k], vi[k], v1, v2, got);
            n_cmp++;
            if (v2 !== 1'b1 || got.e !== EW'(ve[k]) || got.fl !== 5'(vf[k])) begin
                n_fail++;
                $display("FAIL saturate[%0d]: valid=%b exp=%0d flags=%b, want 1 exp=%0d flags=%b",
                         k, v2, got.e, got.fl, ve[k], 5'(vf[k]));
            end
        end
    endtask

    task automatic test_specials();
        int   va[6] = '{0, 255, 0, 0, 255, 255};
        int   vb[6] = '{255, 0, 100, 0, 3, 255};
        int   ve[6] = '{255, 255, 0, 0, 255, 255};
        int   vf[6] = '{5'b00010, 5'b00010, 5'b00100, 5'b00100, 5'b00001, 5'b00001};
        logic v1, v2;
        res_t got;
        for (int k = 0; k < 6; k++) begin
            send_single(va[k], vb[k], 0, v1, v2, got);
            n_cmp++;
            if (v2 !== 1'b1 || got.e !== EW'(ve[k]) || got.fl !== 5'(vf[k])) begin
                n_fail++;
                $display("FAIL special[%0d]: valid=%b exp=%0d flags=%b, want 1 exp=%0d flags=%b",
                         k, v2, got.e, got.fl, ve[k], 5'(vf[k]));
            end
        end
    endtask

    task automatic test_backpressure();
        res_t q[$];
        res_t held, got, want;
        int   a = 0, b = 0, sent = 0, rcvd = 0, first = -1;
        bit   acc = 1'b0;
        held = '0;
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 20 && rcvd < 5; cyc++) begin
            @(negedge clk);
            if (acc) in_valid = 1'b0;
            if (!in_valid && sent < 5) begin
                a = int'($urandom_range(70, 180));
                b = int'($urandom_range(70, 180));
                exp_a = EW'(a); exp_b = EW'(b); norm_inc = 1'b0;
                in_valid = 1'b1;
            end
            out_ready = !(cyc >= 2 && cyc <= 4);
            #1;
            if (cyc == 2) begin
                n_cmp++;
                if (in_ready !== 1'b0 || sent != 2 || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_full: in_ready=%b accepted=%0d out_valid=%b, want 0/2/1",
                             in_ready, sent, out_valid);
                end
                held = observed();
            end
            if (cyc == 3 || cyc == 4) begin
                n_cmp++;
                if (out_valid !== 1'b1 || observed() !== held) begin
                    n_fail++;
                    $display("FAIL bp_stable[%0d]: valid=%b out=%h, want 1 out=%h",
                             cyc, out_valid, observed(), held);
                end
            end
            if (first >= 0) begin
                n_cmp++;
                if (out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_gap[%0d]: out_valid=%b, want 1", cyc, out_valid);
                end
            end
            if (out_valid && out_ready) begin
                if (first < 0) first = cyc;
                got = observed();
                want = (q.size() != 0) ? q.pop_front() : '1;
                n_cmp++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL bp_order[%0d]: out=%h, want %h", rcvd, got, want);
                end
                rcvd++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(model(a, b, 0));
                sent++;
            end
        end
        n_cmp++;
        if (rcvd != 5) begin
            n_fail++;
            $display("FAIL bp_count: received %0d results, want 5", rcvd);
        end
    endtask

    task automatic test_random();
        res_t q[$];
        res_t got, want;
        int   a = 0, b = 0, inc = 0, sent = 0, rcvd = 0, cyc = 0;
        bit   acc = 1'b0;
        logic rdy_want;
        in_valid = 1'b0;
        while (rcvd < 300 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (acc) in_valid = 1'b0;
            if (!in_valid && sent < 300 && $urandom_range(0, 3) != 0) begin
                a = pick_exp(); b = pick_exp(); inc = int'($urandom_range(0, 1));
                exp_a = EW'(a); exp_b = EW'(b); norm_inc = inc[0];
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            rdy_want = !(q.size() == 2 && !out_ready);
            n_cmp++;
            if (in_ready !== rdy_want) begin
                n_fail++;
                $display("FAIL rand_in_ready[%0d]: in_ready=%b, want %b", cyc, in_ready, rdy_want);
            end
            if (out_valid && out_ready) begin
                got = observed();
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_spurious[%0d]: out=%h with nothing in flight", cyc, got);
                end else begin
                    want = q.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL rand_result[%0d]: out=%h, want %h", rcvd, got, want);
                    end
                end
                rcvd++;
            end
            acc = in_valid && in_ready;
            if (acc) begin
                q.push_back(model(a, b, inc));
                sent++;
            end
        end
        n_cmp++;
        if (rcvd != 300) begin
            n_fail++;
            $display("FAIL rand_timeout: received %0d of 300 results", rcvd);
        end
    endtask

    task automatic test_reset_midstream();
        logic v1, v2;
        res_t got, want;
        @(negedge clk);
        exp_a = 8'd100; exp_b = 8'd100; norm_inc = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        exp_a = 8'd150; exp_b = 8'd90;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_full: out_valid=%b in_ready=%b, want 1/0", out_valid, in_ready);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || exp_out !== '0 || {ovf, unf, is_zero, is_nan, is_inf} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_mid_async: valid=%b exp=%0d flags=%b, want 0/0/00000",
                     out_valid, exp_out, {ovf, unf, is_zero, is_nan, is_inf});
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_release: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
        end
        send_single(140, 120, 1, v1, v2, got);
        want = model(140, 120, 1);
        n_cmp++;
        if (v1 !== 1'b0 || v2 !== 1'b1 || got !== want) begin
            n_fail++;
            $display("FAIL rst_mid_first: valid +1/+2=%b/%b out=%h, want 0/1 out=%h", v1, v2, got, want);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_saturation();
        test_specials();
        test_backpressure();
        test_random();
        test_reset_midstream();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
